stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/stopwatch_ctrl.sv | 115 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control path: FSM states, digit selects
// and the per-digit maxima used to clamp switch values in adjust mode.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_ADJ   = 2'd2
    } state_t;

    localparam logic [1:0] MIN_L = 2'd0;
    localparam logic [1:0] MIN_R = 2'd1;
    localparam logic [1:0] SEC_L = 2'd2;
    localparam logic [1:0] SEC_R = 2'd3;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    // Seconds-tens is the only digit limited to 0..5; all others go to 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [1:0] sel);
        logic [3:0] lim;
        lim = (sel == SEC_L) ? TENS_MAX : DIGIT_MAX;
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, stability-counter debouncer and a
// registered one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The count only advances while the synchronized input disagrees with the
    // debounced level; any agreement (a bounce back) restarts it from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel controller: debounces four buttons, runs the
// RUN/PAUSE/ADJ mode FSM and drives registered control outputs to the counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       btn_adj,
    input  logic       btn_sel,
    input  logic [3:0] sw_val,
    output logic       cnt_rst,
    output logic       paused,
    output logic       adj,
    output logic [1:0] adj_sel,
    output logic [3:0] adj_val,
    output logic       adj_we,
    output logic [1:0] state
);

    logic       press_pause;
    logic       press_reset;
    logic       press_adj;
    logic       press_sel;
    logic [3:0] sw_s1;
    logic [3:0] sw_s2;

    state_t     state_q;
    state_t     state_n;
    logic [1:0] sel_n;
    logic       clr_n;
    logic [3:0] val_n;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (.clk(clk), .rst(rst), .btn(btn_pause), .press(press_pause));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_reset (.clk(clk), .rst(rst), .btn(btn_reset), .press(press_reset));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj   (.clk(clk), .rst(rst), .btn(btn_adj),   .press(press_adj));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel   (.clk(clk), .rst(rst), .btn(btn_sel),   .press(press_sel));

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_val;
            sw_s2 <= sw_s1;
        end
    end

    // Presses are resolved strictly by priority reset > adj > pause > sel, so a
    // pause press in ADJ still swallows a simultaneous sel press.
    always_comb begin
        state_n = state_q;
        sel_n   = adj_sel;
        clr_n   = 1'b0;
        if (press_reset) begin
            state_n = ST_PAUSE;
            sel_n   = MIN_L;
            clr_n   = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (press_adj) begin
                        state_n = ST_ADJ;
                        sel_n   = MIN_L;
                    end else if (press_pause) begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (press_adj) begin
                        state_n = ST_ADJ;
                        sel_n   = MIN_L;
                    end else if (press_pause) begin
                        state_n = ST_RUN;
                    end
                end
                ST_ADJ: begin
                    if (press_adj) begin
                        state_n = ST_PAUSE;
                    end else if (!press_pause && press_sel) begin
                        sel_n = adj_sel + 2'd1;
                    end
                end
                default: state_n = ST_PAUSE;
            endcase
        end
        val_n = (state_n == ST_ADJ) ? clamp_digit(sw_s2, sel_n) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PAUSE;
            adj_sel <= MIN_L;
            cnt_rst <= 1'b0;
            paused  <= 1'b1;
            adj     <= 1'b0;
            adj_we  <= 1'b0;
            adj_val <= 4'd0;
        end else begin
            state_q <= state_n;
            adj_sel <= sel_n;
            cnt_rst <= clr_n;
            paused  <= (state_n != ST_RUN);
            adj     <= (state_n == ST_ADJ);
            adj_we  <= (state_n == ST_ADJ);
            adj_val <= val_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEB_CYCLES=4: stimulus queues the
// hand-computed output bundle expected at each output change; a monitor pops it.
module tb_stopwatch_ctrl;

    localparam int DEB = 4;
    localparam int LAT = 2 + DEB + 1 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_reset = 1'b0;
    logic       btn_adj = 1'b0;
    logic       btn_sel = 1'b0;
    logic [3:0] sw_val = 4'd0;
    logic       cnt_rst;
    logic       paused;
    logic       adj;
    logic [1:0] adj_sel;
    logic [3:0] adj_val;
    logic       adj_we;
    logic [1:0] state;

    stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst),
        .btn_pause(btn_pause), .btn_reset(btn_reset), .btn_adj(btn_adj), .btn_sel(btn_sel),
        .sw_val(sw_val),
        .cnt_rst(cnt_rst), .paused(paused), .adj(adj), .adj_sel(adj_sel),
        .adj_val(adj_val), .adj_we(adj_we), .state(state)
    );

    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        logic [11:0] bundle;
        int unsigned at_cycle;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    bit          mon_en = 1'b0;
    logic [11:0] last_seen = 'x;

    // Bundle layout: {state[1:0], paused, adj, adj_sel[1:0], adj_val[3:0], adj_we, cnt_rst}
    function automatic logic [11:0] mk(int st, int p, int a, int sel, int val, int we, int cr);
        return {st[1:0], p[0], a[0], sel[1:0], val[3:0], we[0], cr[0]};
    endfunction

    task automatic push_exp(input string name, input logic [11:0] bundle, input int unsigned at);
        exp_t e;
        e.name     = name;
        e.bundle   = bundle;
        e.at_cycle = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic level);
        case (which)
            0: btn_pause = level;
            1: btn_reset = level;
            2: btn_adj   = level;
            default: btn_sel = level;
        endcase
    endtask

    task automatic press_btn(input int which, input string name, input logic [11:0] bundle);
        push_exp(name, bundle, cycle + LAT);
        applyStimulus(which, 1'b1);
        step(10);
        applyStimulus(which, 1'b0);
        step(10);
    endtask

    task automatic checkOutput(input exp_t e, input logic [11:0] got);
        compared++;
        if (got !== e.bundle || (e.at_cycle != 0 && cycle != e.at_cycle)) begin
            mismatched++;
            $display("[TB] FAIL %s: got bundle=%h at cycle %0d, required bundle=%h at cycle %0d",
                     e.name, got, cycle, e.bundle, e.at_cycle);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [11:0] cur;
        exp_t        e;
        if (mon_en) begin
            cur = {state, paused, adj, adj_sel, adj_val, adj_we, cnt_rst};
            if (cur !== last_seen) begin
                last_seen = cur;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_change: got bundle=%h at cycle %0d, required no change",
                             cur, cycle);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput(e, cur);
                end
            end
        end
    end

    initial begin
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        step(3);
        push_exp("reset_state", mk(1, 1, 0, 0, 0, 0, 0), 0);
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);

        // Bouncing pause button never holds long enough to register.
        for (int i = 0; i < 5; i++) begin
            btn_pause = 1'b1;
            step(2);
            btn_pause = 1'b0;
            step(2);
        end
        step(12);

        push_exp("pause_to_run", mk(0, 0, 0, 0, 0, 0, 0), cycle + LAT);
        btn_pause = 1'b1;
        step(20);
        btn_pause = 1'b0;
        step(12);

        press_btn(0, "run_to_pause", mk(1, 1, 0, 0, 0, 0, 0));
        sw_val = 4'd7;
        step(5);

        press_btn(2, "enter_adj", mk(2, 1, 1, 0, 7, 1, 0));
        press_btn(3, "sel_1", mk(2, 1, 1, 1, 7, 1, 0));
        press_btn(3, "sel_2_clamp", mk(2, 1, 1, 2, 5, 1, 0));
        press_btn(3, "sel_3", mk(2, 1, 1, 3, 7, 1, 0));
        press_btn(3, "sel_wrap_0", mk(2, 1, 1, 0, 7, 1, 0));
        press_btn(3, "sel_1_again", mk(2, 1, 1, 1, 7, 1, 0));

        push_exp("sw8_at_sel1", mk(2, 1, 1, 1, 8, 1, 0), cycle + 3);
        sw_val = 4'd8;
        step(6);
        press_btn(3, "sel_2_sw8", mk(2, 1, 1, 2, 5, 1, 0));
        press_btn(3, "sel_3_sw8", mk(2, 1, 1, 3, 8, 1, 0));
        push_exp("sw15_clamp9", mk(2, 1, 1, 3, 9, 1, 0), cycle + 3);
        sw_val = 4'd15;
        step(6);

        // Reset and adj together: reset wins, adj toggle is discarded.
        push_exp("reset_adj_strobe", mk(1, 1, 0, 0, 0, 0, 1), cycle + LAT);
        push_exp("strobe_end", mk(1, 1, 0, 0, 0, 0, 0), cycle + LAT + 1);
        btn_reset = 1'b1;
        btn_adj   = 1'b1;
        step(12);
        btn_reset = 1'b0;
        btn_adj   = 1'b0;
        step(12);

        press_btn(0, "run_again", mk(0, 0, 0, 0, 0, 0, 0));

        // rst mid-debounce drops the pending press; the held button re-registers once.
        btn_reset = 1'b1;
        step(4);
        push_exp("rst_to_pause", mk(1, 1, 0, 0, 0, 0, 0), cycle + 1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        push_exp("held_reset_strobe", mk(1, 1, 0, 0, 0, 0, 1), cycle + LAT);
        push_exp("held_strobe_end", mk(1, 1, 0, 0, 0, 0, 0), cycle + LAT + 1);
        step(16);
        btn_reset = 1'b0;
        step(20);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
